piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the driving end of our serial shift-register links.
- It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line, one bit per clock.
- Each frame is a one-cycle start bit (1) followed by the data, MSB first. The line sits at 0 when idle.
- Its serial_out feeds the serial_in of our SISO/SIPO shift-register chains and deserializers.

Parameters:
- WIDTH, default 4: data word width in bits. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  parallel word; sampled only on a handshake
- load_valid  input  1  upstream has a word on data_in
- load_ready  output  1  block will accept data_in at this edge if load_valid=1
- serial_out  output  1  registered serial line: idle 0, start bit 1, then data MSB first
- tx_active  output  1  registered; high while a start or data bit is on serial_out
- frame_done  output  1  registered one-cycle pulse, the cycle after the last data bit

Behaviour:
- Reset (reset=0, async): state IDLE, shift register 0, bit counter 0.
  - Outputs: serial_out=0, tx_active=0, frame_done=0, load_ready=1.
  - The handshake is ignored while reset is low.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - data_in is captured into an internal WIDTH-bit shift register at that edge.
  - data_in is a don't-care at all other times.
- load_ready is combinational from state only, with no dependence on load_valid. It is 1 in:
  - IDLE
  - DATA when the bit counter indicates the last bit (bit 0) is being driven
  - It is 0 in all other cases.
- States:
  - IDLE: serial_out=0, tx_active=0. On accept -> START.
  - START: serial_out=1, tx_active=1. Next edge -> DATA with bit counter = WIDTH-1.
  - DATA: serial_out = captured bit[counter], tx_active=1. Counter decrements each edge.
    - When counter=0 and accept: go to START, with the new word captured. There is no idle gap.
    - When counter=0 and no accept: go to IDLE.
- Latency:
  - Accept at edge N gives start bit visible after edge N.
  - data[WIDTH-1] appears after N+1, and data[0] after N+WIDTH.
  - A frame occupies WIDTH+1 cycles.
- frame_done is 1 for exactly the cycle after the edge that leaves DATA (counter=0), whether that edge goes to START or IDLE.
- Back-to-back throughput: one frame per WIDTH+1 cycles with continuous load_valid. frame_done pulses coincide with the next start bit.
- The captured word is stable for the whole frame. Changes on data_in or load_valid during START or non-final DATA have no effect.
- Reset mid-frame: the frame is aborted immediately and the block returns to IDLE values. No frame_done is produced.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH-1; the counter is loaded only on the START -> DATA transition.

Test Plan:
- WIDTH=4, single accept of 4'b1011 after reset, load_valid dropped afterwards:
  - serial_out = 1,1,0,1,1, then 0 steady.
  - tx_active high for 5 cycles.
  - frame_done high 1 cycle, coincident with the first idle 0.
- Back-to-back: load_valid held with 4'b1011 then 4'b0110:
  - serial_out = 1,1,0,1,1,1,0,1,1,0, then 0.
  - load_ready high only in cycles 5 and 10 (the last data bits).
  - Two frame_done pulses.
- Data stability: accept 4'b1001, then toggle data_in to 4'b0110 and hold load_valid=1 during bits 1..3:
  - serial_out = 1,1,0,0,1.
  - No extra accept occurs before the last bit.
- Zero word 4'b0000:
  - serial_out = 1,0,0,0,0, then 0.
  - tx_active=1 for 5 cycles, which distinguishes the frame from idle.
- Reset mid-frame: assert reset=0 asynchronously (between clock edges) during the second data bit:
  - serial_out and tx_active go to 0 immediately; frame_done stays 0; load_ready=1.
  - After release, an accept of 4'b1111 yields 1,1,1,1,1.
- Idle hold: load_valid=0 for 20 cycles after reset:
  - serial_out=0, tx_active=0, load_ready=1, frame_done=0 throughout.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in, serial-out transmitter.
// A word accepted over valid/ready goes out as one start bit (1) and then
// the data bits MSB first, one bit per clock. The line idles at 0.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             tx_active,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             serial_nxt;
  logic             active_nxt;
  logic             done_nxt;
  logic             last_bit;
  logic             accept;

  // The final data bit is on the line, so a new word can follow without a gap.
  assign last_bit   = (state == DATA) && (bit_cnt == '0);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // State, captured word, bit counter and the registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= cnt_nxt;
      serial_out <= serial_nxt;
      tx_active  <= active_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next state plus the line values that will be driven after the next edge.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    cnt_nxt    = bit_cnt;
    serial_nxt = 1'b0;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = START;
          shift_nxt  = data_in;
          serial_nxt = 1'b1;
          active_nxt = 1'b1;
        end
      end
      START: begin
        state_nxt  = DATA;
        cnt_nxt    = CW'(WIDTH - 1);
        serial_nxt = shift_reg[WIDTH-1];
        active_nxt = 1'b1;
      end
      DATA: begin
        if (bit_cnt == '0) begin
          done_nxt = 1'b1;
          if (accept) begin
            state_nxt  = START;
            shift_nxt  = data_in;
            serial_nxt = 1'b1;
            active_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt    = bit_cnt - 1'b1;
          serial_nxt = shift_reg[cnt_nxt];
          active_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx.
// The driver keeps a queue of line bits still to be sent and pushes the
// expected outputs for every cycle; the monitor pops and compares them.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             tx_active;
  logic             frame_done;

  typedef struct packed {
    logic serial;
    logic active;
    logic done;
    logic ready;
  } exp_t;

  typedef struct packed {
    logic b;
    logic last;
  } line_bit_t;

  exp_t      sb_q[$];
  line_bit_t line_q[$];
  logic      prev_last = 1'b0;
  int        n_checks  = 0;
  int        n_fail    = 0;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0b required=%0b at %0t", name, act, req, $time);
    end
  endtask

  // A frame on the line: start bit, then the word MSB first.
  function automatic void push_frame(input logic [WIDTH-1:0] w);
    line_q.push_back('{b: 1'b1, last: 1'b0});
    for (int i = WIDTH - 1; i >= 0; i--) begin
      line_q.push_back('{b: w[i], last: (i == 0)});
    end
  endfunction

  // One clock of stimulus; the model accepts only when nothing remains to send.
  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, output logic accepted);
    exp_t      e;
    line_bit_t x;
    load_valid = v;
    data_in    = d;
    accepted   = v && reset && (line_q.size() == 0);
    @(posedge clk);
    e = '0;
    if (!reset) begin
      line_q.delete();
      prev_last = 1'b0;
    end else begin
      if (accepted) push_frame(d);
      e.done    = prev_last;
      prev_last = 1'b0;
      if (line_q.size() > 0) begin
        x         = line_q.pop_front();
        e.serial  = x.b;
        e.active  = 1'b1;
        prev_last = x.last;
      end
    end
    e.ready = (line_q.size() == 0);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, WIDTH'($urandom), acc);
  endtask

  // Hold valid until the word is taken; junk data is shown while not ready.
  task automatic send_word(input logic [WIDTH-1:0] w);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 2 * (WIDTH + 1) && !acc; k++) begin
      if (line_q.size() == 0) apply_stimulus(1'b1, w, acc);
      else                    apply_stimulus(1'b1, WIDTH'($urandom), acc);
    end
  endtask

  // Monitor: compare the DUT against the expected outputs for each cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output("serial_out", serial_out, e.serial);
      check_output("tx_active",  tx_active,  e.active);
      check_output("frame_done", frame_done, e.done);
      check_output("load_ready", load_ready, e.ready);
    end
  end

  initial begin
    logic acc;
    reset      = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    #1 reset = 1'b0;
    #1;
    check_output("reset_serial", serial_out, 1'b0);
    check_output("reset_active", tx_active,  1'b0);
    check_output("reset_done",   frame_done, 1'b0);
    check_output("reset_ready",  load_ready, 1'b1);
    apply_stimulus(1'b1, 4'b1010, acc);
    apply_stimulus(1'b1, 4'b1010, acc);
    reset = 1'b1;

    $display("[TB] idle hold");
    idle_cycles(20);

    $display("[TB] single frame 1011");
    send_word(4'b1011);
    idle_cycles(7);

    $display("[TB] back-to-back 1011, 0110");
    send_word(4'b1011);
    send_word(4'b0110);
    idle_cycles(7);

    $display("[TB] data stability 1001");
    send_word(4'b1001);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'b0110, acc);
    load_valid = 1'b0;
    idle_cycles(7);

    $display("[TB] zero word");
    send_word(4'b0000);
    idle_cycles(7);

    $display("[TB] reset mid-frame");
    send_word(4'b1010);
    apply_stimulus(1'b0, 4'b0000, acc);
    apply_stimulus(1'b0, 4'b0000, acc);
    @(negedge clk);
    #1;
    reset = 1'b0;
    line_q.delete();
    prev_last = 1'b0;
    #1;
    check_output("abort_serial", serial_out, 1'b0);
    check_output("abort_active", tx_active,  1'b0);
    check_output("abort_done",   frame_done, 1'b0);
    check_output("abort_ready",  load_ready, 1'b1);
    apply_stimulus(1'b1, 4'b1111, acc);
    apply_stimulus(1'b1, 4'b1111, acc);
    reset = 1'b1;
    idle_cycles(2);
    send_word(4'b1111);
    idle_cycles(7);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 9) < 6, WIDTH'($urandom), acc);
    end
    idle_cycles(8);

    @(negedge clk);
    #1;
    check_output("scoreboard_drained", sb_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
